// File: rtl/serial_adder_if.sv
// Requester-side handshake bundle for the bit-serial adder sequencer:
// operands and a start pulse in, a registered result with busy/done status out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell processes one operand bit
// per clock, LSB first, and the result is published in a single edge on completion.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] ps_r;
    logic             c_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_co_s;
    logic             last_s;
    logic [WIDTH-1:0] ps_next_s;

    // Full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // Shared datapath cell and the shifted partial sum it feeds.
    always_comb begin
        fa_sum_s  = 1'b0;
        fa_co_s   = 1'b0;
        {fa_co_s, fa_sum_s} = full_add(sa_r[0], sb_r[0], c_r);
        last_s    = (cnt_r == CNT_W'(WIDTH - 1));
        ps_next_s = WIDTH'({fa_sum_s, ps_r} >> 1'b1);
    end

    // Sequencer FSM with operand, partial-sum and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            ps_r    <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sa_r    <= bus.a;
                        sb_r    <= bus.b;
                        c_r     <= bus.cin;
                        cnt_r   <= {CNT_W{1'b0}};
                        ps_r    <= {WIDTH{1'b0}};
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                RUN: begin
                    ps_r  <= ps_next_s;
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    c_r   <= fa_co_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    // c_r is the carry into the MSB on the final bit, so overflow needs no extra flop.
                    if (last_s) begin
                        sum_r   <= ps_next_s;
                        co_r    <= fa_co_s;
                        ovf_r   <= fa_co_s ^ c_r;
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a cycle-level arithmetic model checked every
// cycle, plus literal expectations from the hand-worked cases.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic check_en = 1'b0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {ovf, co, sum}.
    function automatic logic [W+1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci);
        int u, sx, sy, s;
        logic [W:0] wide;
        u    = int'(x) + int'(y) + int'(ci);
        wide = u[W:0];
        sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
        s    = sx + sy + int'(ci);
        model_add = {(s > (1 << (W-1)) - 1) || (s < -(1 << (W-1))), wide};
    endfunction

    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum, p_sum;
    logic         m_co, p_co, m_ovf, p_ovf;

    // Model: an accepted request keeps the unit busy W cycles, then publishes its result for one done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_done <= 1'b0;
            m_sum <= '0; m_co <= 1'b0; m_ovf <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1; m_sum <= p_sum; m_co <= p_co; m_ovf <= p_ovf;
            end
        end else if (bus.start) begin
            {p_ovf, p_co, p_sum} <= model_add(bus.a, bus.b, bus.cin);
            m_left <= W;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(bus.busy), 32'(m_left > 0));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("sum",  32'(bus.sum),  32'(m_sum));
            chk("co",   32'(bus.co),   32'(m_co));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = ci;
    endtask

    // Follows one operation from just before its accepting edge until done.
    task automatic run(input string name, input logic [W-1:0] prev_sum, input logic [W-1:0] es,
                       input logic ec, input logic eo, input int inject);
        int n, busy_cyc;
        logic seen;
        busy_cyc = 0; seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        chk({name, "_busy_after_e0"}, 32'(bus.busy), 32'd1);
        chk({name, "_done_after_e0"}, 32'(bus.done), 32'd0);
        for (n = 1; n <= 30 && !seen; n++) begin
            if (bus.busy) begin
                busy_cyc++;
                chk({name, "_sum_held"}, 32'(bus.sum), 32'(prev_sum));
            end
            if (inject != 0 && busy_cyc == inject && bus.busy) begin
                bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                chk({name, "_latency"}, 32'(n), 32'(W));
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'(W));
            chk({name, "_sum"}, 32'(bus.sum), 32'(es));
            chk({name, "_co"},  32'(bus.co),  32'(ec));
            chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
        end
    endtask

    task automatic count_done(input string name, input int cycles, input int exp);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk(name, 32'(cnt), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_co",   32'(bus.co),   32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        rst = 1'b0;
        check_en = 1'b1;
        @(negedge clk);

        // Model pins against hand-worked values.
        chk("model_ff_01", 32'(model_add(8'hFF, 8'h01, 1'b0)), 32'h100);
        chk("model_7f_01", 32'(model_add(8'h7F, 8'h01, 1'b0)), 32'h280);
        chk("model_80_80", 32'(model_add(8'h80, 8'h80, 1'b0)), 32'h300);

        issue(8'h00, 8'h00, 1'b0); run("c1_zero", 8'h00, 8'h00, 1'b0, 1'b0, 0);
        @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0); run("c2_carry", 8'h00, 8'h00, 1'b1, 1'b0, 0);
        @(negedge clk);
        issue(8'h7F, 8'h01, 1'b0); run("c2_posovf", 8'h00, 8'h80, 1'b0, 1'b1, 0);
        @(negedge clk);
        issue(8'h80, 8'h80, 1'b0); run("c2_negovf", 8'h80, 8'h00, 1'b1, 1'b1, 0);
        @(negedge clk);
        issue(8'hA5, 8'h5A, 1'b1); run("c3_cin", 8'h00, 8'h00, 1'b1, 1'b0, 0);
        @(negedge clk);
        issue(8'h7F, 8'h00, 1'b1); run("cin_ovf", 8'h00, 8'h80, 1'b0, 1'b1, 0);
        @(negedge clk);
        issue(8'h3C, 8'h0F, 1'b0); run("c4_ignore", 8'h80, 8'h4B, 1'b0, 1'b0, 3);
        count_done("c4_single_done", 12, 0);

        issue(8'h01, 8'h02, 1'b0); run("c5_first", 8'h4B, 8'h03, 1'b0, 1'b0, 0);
        issue(8'h10, 8'h20, 1'b0); run("c5_second", 8'h03, 8'h30, 1'b0, 1'b0, 0);
        @(negedge clk);

        issue(8'h33, 8'h44, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("c6_busy_async", 32'(bus.busy), 32'd0);
        chk("c6_done_async", 32'(bus.done), 32'd0);
        chk("c6_sum_async",  32'(bus.sum),  32'd0);
        chk("c6_co_async",   32'(bus.co),   32'd0);
        chk("c6_ovf_async",  32'(bus.ovf),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done("c6_no_done", 12, 0);
        issue(8'h12, 8'h34, 1'b0); run("c6_fresh", 8'h00, 8'h46, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
